// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Optional build macro BRANCH_PREDICTOR_STATS_EN adds branch/mispredict counters.
module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pred_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic        pred_hit,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken
`ifdef BRANCH_PREDICTOR_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_LSB = INDEX_BITS + 2;
  localparam int TAG_MSB = INDEX_BITS + TAG_BITS + 1;

  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [1:0]          ctr_q    [ENTRIES];
  logic [1:0]          ctr_d    [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_d    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [31:0]         target_d [ENTRIES];

  logic [INDEX_BITS-1:0] pred_idx, upd_idx;
  logic [TAG_BITS-1:0]   pred_tag, upd_tag;
  logic                  upd_hit, upd_en;

  assign pred_idx = pred_pc[INDEX_BITS+1:2];
  assign pred_tag = pred_pc[TAG_MSB:TAG_LSB];
  assign upd_idx  = upd_pc[INDEX_BITS+1:2];
  assign upd_tag  = upd_pc[TAG_MSB:TAG_LSB];

  // Lookup reads pre-update state only; a same-cycle update is not bypassed.
  assign pred_hit    = valid_q[pred_idx] && (tag_q[pred_idx] == pred_tag);
  assign pred_taken  = pred_hit && ctr_q[pred_idx][1];
  assign pred_target = pred_taken ? target_q[pred_idx] : pred_pc + 32'd4;

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_en  = upd_valid && !rst;

  always_comb begin
    // NOTE: every target gets a default copy of current state first, so no path leaves a latch.
    valid_d  = valid_q;
    ctr_d    = ctr_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (upd_en) begin
      if (upd_hit) begin
        if (upd_taken) begin
          if (ctr_q[upd_idx] != 2'b11) ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
          target_d[upd_idx] = upd_target;
        end else if (ctr_q[upd_idx] != 2'b00) begin
          ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = upd_target;
        ctr_d[upd_idx]    = 2'b10;
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  // NOTE: tag/target storage has no reset; clearing valid makes its contents irrelevant.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (upd_en) begin
      stat_branches_d = stat_branches_q + 32'd1;
      if (upd_pred_taken != upd_taken) stat_mispredicts_d = stat_mispredicts_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc, upd_pc};
`else
  // Byte-offset bits and the statistics-only input have no function in this build.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc, upd_pc, upd_pred_taken};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: stimulus pushes expected lookups,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        pred_hit;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  branch_predictor dut (
    .clk            (clk),
    .rst            (rst),
    .pred_pc        (pred_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .pred_hit       (pred_hit),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_pred_taken (upd_pred_taken)
`ifdef BRANCH_PREDICTOR_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic        taken;
    logic [31:0] target;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  logic  obs_valid = 1'b0;
  int    n_cmp  = 0;
  int    n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: the lookup presented in a cycle is sampled at the falling edge.
  always @(negedge clk) begin
    if (obs_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL scoreboard_underrun: got output with no expectation queued");
      end else begin
        exp_t  e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check({nm, ".hit"},    {31'd0, pred_hit},   {31'd0, e.hit});
        check({nm, ".taken"},  {31'd0, pred_taken}, {31'd0, e.taken});
        check({nm, ".target"}, pred_target,         e.target);
      end
    end
  end

  // One cycle of stimulus; the update (if any) lands at the end of this cycle.
  task automatic step(input logic r, input logic [31:0] pc,
                      input logic uv, input logic [31:0] upc, input logic ut,
                      input logic [31:0] utgt, input logic upt,
                      input logic chk, input logic eh, input logic et,
                      input logic [31:0] etgt, input string nm);
    @(posedge clk);
    #1;
    rst            = r;
    pred_pc        = pc;
    upd_valid      = uv;
    upd_pc         = upc;
    upd_taken      = ut;
    upd_target     = utgt;
    upd_pred_taken = upt;
    obs_valid      = chk;
    if (chk) begin
      exp_q.push_back('{eh, et, etgt});
      name_q.push_back(nm);
    end
  endtask

  localparam logic T = 1'b1;
  localparam logic N = 1'b0;

  initial begin
    rst = 1'b1; pred_pc = '0; upd_valid = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0;

    //   rst pc            uv upc           ut tgt           upt chk hit tk  exp_target     name
    step(T, 32'h100,      N, 32'h0,      N, 32'h0,      N, N, N, N, 32'h0,      "pre_reset");
    step(T, 32'h100,      N, 32'h0,      N, 32'h0,      N, T, N, N, 32'h104,    "reset_lookup");
    step(N, 32'h100,      T, 32'h100,    T, 32'h80,     N, T, N, N, 32'h104,    "alloc_same_cycle");
    step(N, 32'h100,      T, 32'h100,    T, 32'h80,     N, T, T, T, 32'h80,     "alloc_ctr10");
    step(N, 32'h100,      T, 32'h100,    T, 32'h80,     N, T, T, T, 32'h80,     "ctr11");
    step(N, 32'h100,      T, 32'h100,    T, 32'h80,     N, T, T, T, 32'h80,     "ctr11_sat");
    step(N, 32'h100,      T, 32'h100,    N, 32'hDEAD0,  N, T, T, T, 32'h80,     "ctr11_before_nt");
    step(N, 32'h100,      T, 32'h100,    N, 32'hDEAD0,  N, T, T, T, 32'h80,     "ctr10_hyst");
    step(N, 32'h100,      N, 32'h0,      N, 32'h0,      N, T, T, N, 32'h104,    "ctr01_nt");
    step(N, 32'h100,      T, 32'h100,    T, 32'h90,     N, T, T, N, 32'h104,    "ctr01_retrain");
    step(N, 32'h100,      T, 32'h100,    N, 32'h0,      N, T, T, T, 32'h90,     "target_overwrite");
    step(N, 32'h100,      T, 32'h100,    N, 32'h0,      N, T, T, N, 32'h104,    "ctr01_down");
    step(N, 32'h100,      T, 32'h100,    N, 32'h0,      N, T, T, N, 32'h104,    "ctr00_down");
    step(N, 32'h100,      N, 32'h0,      N, 32'h0,      N, T, T, N, 32'h104,    "ctr00_sat");
    step(N, 32'h500,      T, 32'h500,    N, 32'h44,     N, T, N, N, 32'h504,    "miss_nt_same");
    step(N, 32'h500,      N, 32'h0,      N, 32'h0,      N, T, N, N, 32'h504,    "miss_nt_no_alloc");
    step(N, 32'h100,      T, 32'h200,    T, 32'h40,     N, T, T, N, 32'h104,    "alias_before");
    step(N, 32'h100,      N, 32'h0,      N, 32'h0,      N, T, N, N, 32'h104,    "alias_evicted");
    step(N, 32'h200,      N, 32'h0,      N, 32'h0,      N, T, T, T, 32'h40,     "alias_new");
    step(N, 32'h300,      T, 32'h300,    T, 32'h1000,   N, T, N, N, 32'h304,    "hazard_same_cycle");
    step(N, 32'h300,      N, 32'h0,      N, 32'h0,      N, T, T, T, 32'h1000,   "hazard_next_cycle");
    step(N, 32'hFFFFFFFC, N, 32'h0,      N, 32'h0,      N, T, N, N, 32'h0,      "pc_wrap");
    step(N, 32'h303,      N, 32'h0,      N, 32'h0,      N, T, T, T, 32'h1000,   "low_bits_ignored");
    step(T, 32'h300,      T, 32'h600,    T, 32'h70,     N, T, T, T, 32'h1000,   "rst_with_update");
    step(N, 32'h600,      N, 32'h0,      N, 32'h0,      N, T, N, N, 32'h604,    "rst_drops_update");
    step(N, 32'h300,      N, 32'h0,      N, 32'h0,      N, T, N, N, 32'h304,    "rst_clears_300");
    step(N, 32'h200,      N, 32'h0,      N, 32'h0,      N, T, N, N, 32'h204,    "rst_clears_200");

`ifdef BRANCH_PREDICTOR_STATS_EN
    step(T, 32'h0,        N, 32'h0,      N, 32'h0,      N, N, N, N, 32'h0,      "stats_rst");
    step(N, 32'h0,        T, 32'h700,    T, 32'h10,     N, N, N, N, 32'h0,      "stats_u1");
    step(N, 32'h0,        T, 32'h700,    T, 32'h10,     T, N, N, N, 32'h0,      "stats_u2");
    step(N, 32'h0,        T, 32'h700,    N, 32'h10,     N, N, N, N, 32'h0,      "stats_u3");
    step(N, 32'h0,        T, 32'h704,    N, 32'h10,     T, N, N, N, 32'h0,      "stats_u4");
    step(N, 32'h0,        T, 32'h708,    T, 32'h10,     T, N, N, N, 32'h0,      "stats_u5");
    step(N, 32'h0,        N, 32'h0,      N, 32'h0,      N, N, N, N, 32'h0,      "stats_idle");
    @(negedge clk);
    check("stat_branches",    stat_branches,    32'd5);
    check("stat_mispredicts", stat_mispredicts, 32'd2);
    step(N, 32'h0,        N, 32'h0,      N, 32'h0,      N, N, N, N, 32'h0,      "stats_hold");
    @(negedge clk);
    check("stat_branches_hold", stat_branches, 32'd5);
    step(T, 32'h0,        T, 32'h700,    N, 32'h0,      T, N, N, N, 32'h0,      "stats_rst2");
    step(N, 32'h0,        N, 32'h0,      N, 32'h0,      N, N, N, N, 32'h0,      "stats_after_rst");
    @(negedge clk);
    check("stat_branches_rst",    stat_branches,    32'd0);
    check("stat_mispredicts_rst", stat_mispredicts, 32'd0);
`endif

    @(posedge clk);
    #1;
    obs_valid = 1'b0;
    upd_valid = 1'b0;
    rst       = 1'b0;

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Direct-mapped branch target buffer with 2-bit saturating counters, sitting in the fetch stage.
- Produces a taken/not-taken guess and a target for the PC being fetched.
- Is trained by the execute-stage branch comparison result: the comparator resolves branches, and this block predicts them and consumes the resolution.
- Prediction lookup is combinational from table state. Training takes effect on the next clock edge.

Parameters:
- INDEX_BITS, 6, log2 of entry count (64 entries); index = pc[INDEX_BITS+1:2].
- TAG_BITS, 24, stored tag width; tag = pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]. INDEX_BITS+TAG_BITS must be ≤ 30.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- pred_pc  in  32  fetch PC to predict
- pred_taken  out  1  predicted taken
- pred_target  out  32  predicted next PC
- pred_hit  out  1  lookup hit a valid entry with matching tag
- upd_valid  in  1  a conditional branch resolved this cycle
- upd_pc  in  32  PC of the resolved branch
- upd_taken  in  1  resolved direction (comparator output)
- upd_target  in  32  computed branch target
- upd_pred_taken  in  1  direction that was predicted for this branch (used for statistics only)

Behaviour:
- Entry fields: valid (1), tag (TAG_BITS), target (32), ctr (2).
  - ctr encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Reset (rst=1 at a rising edge): all valid bits cleared, all ctr set to 01. Tags and targets may stay undefined.
  - Outputs while rst is asserted follow the same combinational lookup and read as a miss after the first reset edge: pred_hit=0, pred_taken=0, pred_target=pred_pc+4.
  - rst overrides upd_valid in the same cycle; the update is dropped.
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag[idx]==pred_pc tag bits.
  - pred_hit = hit.
  - pred_taken = hit && ctr[idx][1].
  - pred_target = pred_taken ? target[idx] : pred_pc+4. The add is 32-bit and wraps modulo 2^32; 0xFFFFFFFC+4 gives 0x00000000.
- Update (on the clock edge with upd_valid=1 and rst=0):
  - Hit on upd_pc:
    - ctr += 1 if upd_taken, saturating at 11.
    - ctr -= 1 if not taken, saturating at 00.
    - If upd_taken, target is overwritten with upd_target.
  - Miss and upd_taken=1: allocate the entry, replacing whatever occupies it. Set valid=1, tag=upd_pc tag, target=upd_target, ctr=10.
  - Miss and upd_taken=0: no state change.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents (no bypass); the new value is visible the following cycle.
- upd_pc[1:0] and pred_pc[1:0] are ignored.
- No handshake: one update per cycle maximum, always accepted.

Optional Feature:
- Macro: BRANCH_PREDICTOR_STATS_EN.
- Defined: adds outputs stat_branches[31:0] and stat_mispredicts[31:0]. Both reset to 0.
  - stat_branches increments on every accepted update.
  - stat_mispredicts increments when upd_pred_taken != upd_taken.
  - Both wrap from 0xFFFFFFFF to 0.
  - Both hold their value while upd_valid=0.
- Undefined: these ports and counters do not exist. The prediction and update behaviour is identical in both builds.

Test Plan:
- Reset, then pred_pc=0x00000100 → pred_hit=0, pred_taken=0, pred_target=0x00000104.
- Update taken, upd_pc=0x100, upd_target=0x80 → next cycle pred_pc=0x100 gives pred_hit=1, pred_taken=1, pred_target=0x80 (ctr=10).
- Saturation and hysteresis on the 0x100 entry:
  - Three more taken updates → ctr=11.
  - One not-taken update → ctr=10, still predicts taken.
  - A second not-taken update → ctr=01, pred_taken=0, pred_target=0x104.
- Aliasing: entry at 0x100 valid, then taken update at 0x100+(1<<8)=0x200 with target 0x40 (same index, different tag) → 0x100 now misses (pred_hit=0) and 0x200 hits with target 0x40.
- Same-cycle hazard and reset priority:
  - Lookup 0x300 while the first taken update to 0x300 is applied → that cycle pred_hit=0; the next cycle pred_hit=1.
  - rst and upd_valid together → table empty afterwards.
- With BRANCH_PREDICTOR_STATS_EN: apply 5 updates, 2 with upd_pred_taken != upd_taken → stat_branches=5, stat_mispredicts=2. After rst, both are 0.
